// File: rtl/signed_multiplier.sv
// rtl/signed_multiplier.sv - Sequential radix-2 Booth signed multiplier, 2N-bit product
// Optional overflow flag port ovf is built only when SMUL_OVF_EN is defined.
module signed_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   databus,
  input  logic           ldm,
  input  logic           ldq,
  input  logic           st,
  output logic [2*N-1:0] prod,
  output logic           busy,
  output logic           done
`ifdef SMUL_OVF_EN
  ,
  output logic           ovf
`endif
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic [N-1:0]   m_q;
  logic [N-1:0]   q_q;
  logic [N:0]     a_q;
  logic [N-1:0]   qr_q;
  logic           q1_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] prod_q;
  logic           busy_q;
  logic           done_q;

  logic [N:0]     m_ext;
  logic [N:0]     sum;
  logic [N:0]     a_d;
  logic [N-1:0]   qr_d;
  logic           q1_d;
  logic [2*N-1:0] prod_d;
  logic           start;

  // Start only from IDLE and only when no operand load competes for the cycle.
  assign start = st && !ldm && !ldq;

  always_comb begin
    m_ext = {m_q[N-1], m_q};
    sum   = a_q;
    case ({qr_q[0], q1_q})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase
    a_d    = {sum[N], sum[N:1]};
    qr_d   = {sum[0], qr_q[N-1:1]};
    q1_d   = qr_q[0];
    prod_d = {a_d[N-1:0], qr_d};
  end

`ifdef SMUL_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Fits in N bits only when the top N+1 product bits are a pure sign extension.
  always_comb begin
    ovf_d = !((&prod_d[2*N-1:N-1]) || !(|prod_d[2*N-1:N-1]));
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      qr_q    <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SMUL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ldm) m_q <= databus;
          if (ldq) q_q <= databus;
          if (start) begin
            a_q     <= '0;
            qr_q    <= q_q;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b1;
`ifdef SMUL_OVF_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q   <= a_d;
          qr_q  <= qr_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            prod_q  <= prod_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef SMUL_OVF_EN
            ovf_q   <= ovf_d;
`endif
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (ldm) m_q <= databus;
          if (ldq) q_q <= databus;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign prod = prod_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_signed_multiplier.sv
// tb/tb_signed_multiplier.sv - Randomized self-checking bench for signed_multiplier
// Expected products come from plain integer multiplication of the loaded operands.
module tb_signed_multiplier;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   databus;
  logic           ldm;
  logic           ldq;
  logic           st;
  logic [2*N-1:0] prod;
  logic           busy;
  logic           done;
`ifdef SMUL_OVF_EN
  logic           ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [2*N-1:0] last_prod = '0;

  signed_multiplier #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .databus (databus),
    .ldm     (ldm),
    .ldq     (ldq),
    .st      (st),
    .prod    (prod),
    .busy    (busy),
    .done    (done)
`ifdef SMUL_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic lm, input logic lq, input logic [N-1:0] v);
    ldm = lm; ldq = lq; databus = v;
    tick();
    ldm = 1'b0; ldq = 1'b0;
  endtask

  task automatic start_run;
    st = 1'b1;
    tick();
    st = 1'b0;
  endtask

  // Counts cycles from the current sample point until done; prod must stay 0 meanwhile.
  task automatic wait_done(output int cyc, output int bc, output bit partial);
    cyc = 0; bc = 0; partial = 1'b0;
    while (!done && cyc < 40) begin
      if (busy) bc++;
      if (prod !== '0) partial = 1'b1;
      tick();
      cyc++;
    end
  endtask

  task automatic check_result(input string name, input int em, input int eq);
    logic [2*N-1:0] exp_p;
    int p;
    p = em * eq;
    exp_p = (2*N)'(p);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s timeout: done=%b required 1", name, done);
    end
    checks++;
    if (prod !== exp_p) begin
      errors++; $display("FAIL %s prod: got %h required %h", name, prod, exp_p);
    end
`ifdef SMUL_OVF_EN
    checks++;
    if (ovf !== ((p < -(1 << (N-1))) || (p > (1 << (N-1)) - 1))) begin
      errors++; $display("FAIL %s ovf: got %b required %b", name, ovf,
                         (p < -(1 << (N-1))) || (p > (1 << (N-1)) - 1));
    end
`endif
    last_prod = exp_p;
  endtask

  task automatic run_check(input string name, input int em, input int eq);
    int cyc, bc;
    bit partial;
    start_run();
    wait_done(cyc, bc, partial);
    checks++;
    if (cyc !== N) begin
      errors++; $display("FAIL %s latency: got %0d required %0d", name, cyc, N);
    end
    checks++;
    if (bc !== N) begin
      errors++; $display("FAIL %s busy_cycles: got %0d required %0d", name, bc, N);
    end
    checks++;
    if (partial) begin
      errors++; $display("FAIL %s partial_prod: got nonzero prod during run required 0", name);
    end
    check_result(name, em, eq);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || prod !== last_prod) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b prod=%h required 0 0 %h",
               name, done, busy, prod, last_prod);
    end
  endtask

  task automatic run_vec(input string name, input int a, input int b);
    load(1'b1, 1'b0, N'(a));
    load(1'b0, 1'b1, N'(b));
    run_check(name, a, b);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (prod !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got prod=%h busy=%b done=%b required 0 0 0", prod, busy, done);
    end
`ifdef SMUL_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %b required 0", ovf);
    end
`endif
    rst_n = 1'b1;
    tick();
    run_check("reset_operands_zero", 0, 0);
  endtask

  task automatic test_vectors;
    run_vec("7x-3", 7, -3);
    run_vec("-128x-128", -128, -128);
    run_vec("-128x127", -128, 127);
    run_vec("100x2", 100, 2);
    run_vec("-64x2", -64, 2);
    run_vec("127x127", 127, 127);
    run_vec("-1x1", -1, 1);
  endtask

  task automatic test_square;
    load(1'b1, 1'b1, N'(5));
    run_check("square5", 5, 5);
  endtask

  task automatic test_start_with_load;
    st = 1'b1; ldm = 1'b1; databus = N'(3);
    tick();
    st = 1'b0; ldm = 1'b0;
    checks++;
    if (busy !== 1'b0 || prod !== last_prod) begin
      errors++;
      $display("FAIL st_with_ld: got busy=%b prod=%h required 0 %h", busy, prod, last_prod);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL st_with_ld_idle: got busy=%b done=%b required 0 0", busy, done);
    end
    run_check("loaded_3x5", 3, 5);
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    bit partial;
    load(1'b1, 1'b0, N'(-7));
    load(1'b0, 1'b1, N'(11));
    start_run();
    tick(); tick();
    st = 1'b1; ldm = 1'b1; databus = N'(9);
    tick();
    st = 1'b0; ldm = 1'b0;
    wait_done(cyc, bc, partial);
    checks++;
    if (cyc !== N - 3) begin
      errors++; $display("FAIL midrun_latency: got %0d required %0d", cyc, N - 3);
    end
    check_result("midrun_ignored", -7, 11);
    st = 1'b1;
    tick();
    st = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL st_in_done: got busy=%b done=%b required 0 0", busy, done);
    end
    run_check("repeat_no_reload", -7, 11);
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    load(1'b1, 1'b0, N'(13));
    load(1'b0, 1'b1, N'(-6));
    start_run();
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || prod !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b prod=%h done=%b required 0 0 0", busy, prod, done);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      if (done || busy) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midrun_reset_quiet: got done/busy activity required none");
    end
    run_check("after_reset_idle", 0, 0);
  endtask

  task automatic test_random;
    logic [N-1:0] ra, rb;
    for (int i = 0; i < 30; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        load(1'b1, 1'b1, ra);
        run_check("rand_square", int'($signed(ra)), int'($signed(ra)));
      end else begin
        load(1'b0, 1'b1, rb);
        load(1'b1, 1'b0, ra);
        run_check("rand", int'($signed(ra)), int'($signed(rb)));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; databus = '0; ldm = 1'b0; ldq = 1'b0; st = 1'b0;
    test_reset();
    test_vectors();
    test_square();
    test_start_with_load();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
